ir_scan_checker: RTL and testbench

IR_SCAN_CHECKER -- requirements
Module: ir_scan_checker

---
 rtl/ir_chk_pkg.sv | 22 ++
 rtl/ir_chk_sat_cnt.sv | 41 ++++
 rtl/ir_scan_checker.sv | 183 ++++++++++++++++++
 tb/tb_ir_scan_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ir_chk_pkg.sv
// ---------------------------------------------------------------------------
// ir_chk_pkg
// Shared definitions for the IR scan checker:
//   - ir_state_e     : checker FSM state encoding (2 bits, visible on a port)
//   - CNT_WIDTH_DEF  : default width of the shift-edge counter
//   - ERR_CAP_MISMATCH / ERR_NO_CAPTURE : bit positions inside err_flags
// ---------------------------------------------------------------------------
package ir_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_CHECKED  = 2'd3
  } ir_state_e;

  localparam int CNT_WIDTH_DEF = 8;

  localparam int ERR_CAP_MISMATCH = 0;
  localparam int ERR_NO_CAPTURE   = 1;

endpackage

// File: rtl/ir_chk_sat_cnt.sv
// ---------------------------------------------------------------------------
// ir_chk_sat_cnt
// Saturating up-counter used to count IR shift edges since the last capture.
// Ports:
//   clockIR     : counting clock, rising edge
//   rst_instr_n : asynchronous active-low reset (count -> 0)
//   enable      : advance by one on this edge (ignored once saturated)
//   clear       : synchronous clear, has priority over enable
//   count       : current count (registered)
//   saturated   : count is all-ones
// ---------------------------------------------------------------------------
module ir_chk_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clockIR,
  input  logic         rst_instr_n,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         saturated
);

  logic [W-1:0] count_r;

  // Count register: clear wins, otherwise advance until all-ones then hold.
  always_ff @(posedge clockIR or negedge rst_instr_n) begin
    if (!rst_instr_n) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && !(&count_r)) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count     = count_r;
  assign saturated = &count_r;

endmodule

// File: rtl/ir_scan_checker.sv
// ---------------------------------------------------------------------------
// ir_scan_checker
// Watches a JTAG instruction-register scan on the gated IR clock and checks
// that the word shifted out after a capture equals the expected capture value
// (whose two LSBs must also be 2'b01). Also collects the instruction being
// shifted in.
// Ports:
//   clockIR      : gated IR clock, only capture and shift edges
//   rst_instr_n  : asynchronous active-low reset
//   shiftIR      : 1 = shift edge, 0 = capture edge
//   tdi_bit      : bit entering the IR chain on this edge
//   tdo_bit      : bit leaving the IR chain on this edge
//   exp_capture  : expected capture word, sampled on the final observe edge
//   state        : checker FSM state (ir_state_e encoding)
//   shift_cnt    : shift edges since last capture, saturating
//   cap_done     : whole captured word has been observed
//   cap_match    : observed word matched exp_capture with LSBs 2'b01
//   pend_instr   : last IR_WIDTH tdi bits, first-shifted bit in LSB
//   pend_valid   : at least IR_WIDTH shifts since capture
//   err_flags    : sticky errors (capture mismatch, shift without capture)
// ---------------------------------------------------------------------------
module ir_scan_checker
  import ir_chk_pkg::*;
#(
  parameter int IR_WIDTH  = 4,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clockIR,
  input  logic                 rst_instr_n,
  input  logic                 shiftIR,
  input  logic                 tdi_bit,
  input  logic                 tdo_bit,
  input  logic [IR_WIDTH-1:0]  exp_capture,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] shift_cnt,
  output logic                 cap_done,
  output logic                 cap_match,
  output logic [IR_WIDTH-1:0]  pend_instr,
  output logic                 pend_valid,
  output logic [1:0]           err_flags
);

  localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(IR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] K_END  = CNT_WIDTH'(IR_WIDTH);

  // Observed word is accepted only if it equals the expectation and its
  // two LSBs carry the mandatory 2'b01 IR capture pattern.
  function automatic logic word_ok(input logic [IR_WIDTH-1:0] word,
                                   input logic [IR_WIDTH-1:0] expect_w);
    return (word == expect_w) && (word[1:0] == 2'b01);
  endfunction

  ir_state_e            state_r;
  ir_state_e            state_nxt_s;
  logic [IR_WIDTH-1:0]  obs_r,  obs_nxt_s;
  logic [IR_WIDTH-1:0]  pend_r, pend_nxt_s;
  logic                 done_r, done_nxt_s;
  logic                 match_r, match_nxt_s;
  logic                 pv_r, pv_nxt_s;
  logic [1:0]           err_r, err_nxt_s;
  logic [IR_WIDTH-1:0]  word_s;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic                 cnt_sat_s;
  logic                 active_s;
  logic                 k_in_s;
  logic                 k_last_s;

  assign active_s = (state_r != ST_IDLE);
  // A saturated count no longer identifies a chain position, so treat it as
  // past the end of the word.
  assign k_in_s   = !cnt_sat_s && (cnt_s < K_END);
  assign k_last_s = !cnt_sat_s && (cnt_s == K_LAST);
  // Completed word: earlier bits from the observe register, MSB arrives now.
  assign word_s   = {tdo_bit, obs_r[IR_WIDTH-2:0]};

  ir_chk_sat_cnt #(
    .W (CNT_WIDTH)
  ) u_sat_cnt (
    .clockIR     (clockIR),
    .rst_instr_n (rst_instr_n),
    .enable      (shiftIR && active_s),
    .clear       (!shiftIR),
    .count       (cnt_s),
    .saturated   (cnt_sat_s)
  );

  // FSM state register.
  always_ff @(posedge clockIR or negedge rst_instr_n) begin
    if (!rst_instr_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: a capture edge restarts from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (!shiftIR) begin
      state_nxt_s = ST_CAPTURED;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = ST_IDLE;
        ST_CAPTURED,
        ST_SHIFTING: begin
          if (k_last_s) begin
            state_nxt_s = ST_CHECKED;
          end else if (k_in_s) begin
            state_nxt_s = ST_SHIFTING;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_CHECKED: state_nxt_s = ST_CHECKED;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output logic: next values of the observe/result/error registers.
  always_comb begin
    obs_nxt_s   = obs_r;
    pend_nxt_s  = pend_r;
    done_nxt_s  = done_r;
    match_nxt_s = match_r;
    pv_nxt_s    = pv_r;
    err_nxt_s   = err_r;
    if (!shiftIR) begin
      // Capture: drop any partial result; pending instruction is kept.
      obs_nxt_s   = {IR_WIDTH{1'b0}};
      done_nxt_s  = 1'b0;
      match_nxt_s = 1'b0;
      pv_nxt_s    = 1'b0;
    end else if (!active_s) begin
      err_nxt_s[ERR_NO_CAPTURE] = 1'b1;
    end else begin
      pend_nxt_s = {tdi_bit, pend_r[IR_WIDTH-1:1]};
      for (int i = 0; i < IR_WIDTH; i++) begin
        obs_nxt_s[i] = (k_in_s && (cnt_s == CNT_WIDTH'(i))) ? tdo_bit : obs_r[i];
      end
      if (k_last_s) begin
        done_nxt_s  = 1'b1;
        pv_nxt_s    = 1'b1;
        match_nxt_s = word_ok(word_s, exp_capture);
        if (!word_ok(word_s, exp_capture)) begin
          err_nxt_s[ERR_CAP_MISMATCH] = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end else begin
        done_nxt_s = done_r;
      end
    end
  end

  // Output/result registers.
  always_ff @(posedge clockIR or negedge rst_instr_n) begin
    if (!rst_instr_n) begin
      obs_r   <= {IR_WIDTH{1'b0}};
      pend_r  <= {IR_WIDTH{1'b0}};
      done_r  <= 1'b0;
      match_r <= 1'b0;
      pv_r    <= 1'b0;
      err_r   <= 2'b00;
    end else begin
      obs_r   <= obs_nxt_s;
      pend_r  <= pend_nxt_s;
      done_r  <= done_nxt_s;
      match_r <= match_nxt_s;
      pv_r    <= pv_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign state      = state_r;
  assign shift_cnt  = cnt_s;
  assign cap_done   = done_r;
  assign cap_match  = match_r;
  assign pend_instr = pend_r;
  assign pend_valid = pv_r;
  assign err_flags  = err_r;

endmodule

// File: tb/tb_ir_scan_checker.sv
// ---------------------------------------------------------------------------
// tb_ir_scan_checker
// Directed bench for ir_scan_checker with IR_WIDTH=4, CNT_WIDTH=8.
// ---------------------------------------------------------------------------
module tb_ir_scan_checker;

  logic       clockIR;
  logic       rst_instr_n;
  logic       shiftIR;
  logic       tdi_bit;
  logic       tdo_bit;
  logic [3:0] exp_capture;
  logic [1:0] state;
  logic [7:0] shift_cnt;
  logic       cap_done;
  logic       cap_match;
  logic [3:0] pend_instr;
  logic       pend_valid;
  logic [1:0] err_flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sh;
    logic       tdi;
    logic       tdo;
    logic [3:0] exp_cap;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       done;
    logic       match;
    logic [3:0] pend;
    logic       pv;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[24];

  ir_scan_checker #(
    .IR_WIDTH  (4),
    .CNT_WIDTH (8)
  ) dut (
    .clockIR     (clockIR),
    .rst_instr_n (rst_instr_n),
    .shiftIR     (shiftIR),
    .tdi_bit     (tdi_bit),
    .tdo_bit     (tdo_bit),
    .exp_capture (exp_capture),
    .state       (state),
    .shift_cnt   (shift_cnt),
    .cap_done    (cap_done),
    .cap_match   (cap_match),
    .pend_instr  (pend_instr),
    .pend_valid  (pend_valid),
    .err_flags   (err_flags)
  );

  function automatic vec_t mk(logic sh, logic tdi, logic tdo, logic [3:0] exp_cap,
                              logic [1:0] st, logic [7:0] cnt, logic done, logic match,
                              logic [3:0] pend, logic pv, logic [1:0] err);
    vec_t v;
    v.sh = sh; v.tdi = tdi; v.tdo = tdo; v.exp_cap = exp_cap;
    v.st = st; v.cnt = cnt; v.done = done; v.match = match;
    v.pend = pend; v.pv = pv; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [7:0] cnt,
                           input logic done, input logic match, input logic [3:0] pend,
                           input logic pv, input logic [1:0] err);
    check({tag, ".state"},      32'(state),      32'(st));
    check({tag, ".shift_cnt"},  32'(shift_cnt),  32'(cnt));
    check({tag, ".cap_done"},   32'(cap_done),   32'(done));
    check({tag, ".cap_match"},  32'(cap_match),  32'(match));
    check({tag, ".pend_instr"}, 32'(pend_instr), 32'(pend));
    check({tag, ".pend_valid"}, 32'(pend_valid), 32'(pv));
    check({tag, ".err_flags"},  32'(err_flags),  32'(err));
  endtask

  // One gated IR clock pulse; outputs are sampled after it falls again.
  task automatic edge_ir(input logic sh, input logic tdi, input logic tdo, input logic [3:0] e);
    shiftIR = sh; tdi_bit = tdi; tdo_bit = tdo; exp_capture = e;
    #5 clockIR = 1'b1;
    #5 clockIR = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_instr_n = 1'b0;
    #3 rst_instr_n = 1'b1;
    #2;
  endtask

  initial begin
    logic [3:0] model_pend;
    logic       t;

    clockIR = 1'b0; rst_instr_n = 1'b1; shiftIR = 1'b0;
    tdi_bit = 1'b0; tdo_bit = 1'b0; exp_capture = 4'b0000;

    // Table: good check, partial scan then good check, over-shift,
    // LSB-pattern failure, value mismatch.
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 4'b0001, 2'd1, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 4'b1111, 2'd2, 8'd1, 1'b0, 1'b0, 4'b1000, 1'b0, 2'b00);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 4'b1111, 2'd2, 8'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 2'b00);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 4'b1111, 2'd2, 8'd3, 1'b0, 1'b0, 4'b0110, 1'b0, 2'b00);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 4'b0001, 2'd3, 8'd4, 1'b1, 1'b1, 4'b1011, 1'b1, 2'b00);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 8'd0, 1'b0, 1'b0, 4'b1011, 1'b0, 2'b00);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 4'b0000, 2'd2, 8'd1, 1'b0, 1'b0, 4'b0101, 1'b0, 2'b00);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 8'd2, 1'b0, 1'b0, 4'b0010, 1'b0, 2'b00);
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 4'b0000, 2'd1, 8'd0, 1'b0, 1'b0, 4'b0010, 1'b0, 2'b00);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 4'b1000, 2'd2, 8'd1, 1'b0, 1'b0, 4'b1001, 1'b0, 2'b00);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 4'b1000, 2'd2, 8'd2, 1'b0, 1'b0, 4'b0100, 1'b0, 2'b00);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 4'b1000, 2'd2, 8'd3, 1'b0, 1'b0, 4'b1010, 1'b0, 2'b00);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 4'b0001, 2'd3, 8'd4, 1'b1, 1'b1, 4'b0101, 1'b1, 2'b00);
    vecs[13] = mk(1'b1, 1'b1, 1'b1, 4'b1111, 2'd3, 8'd5, 1'b1, 1'b1, 4'b1010, 1'b1, 2'b00);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, 8'd0, 1'b0, 1'b0, 4'b1010, 1'b0, 2'b00);
    vecs[15] = mk(1'b1, 1'b0, 1'b1, 4'b1111, 2'd2, 8'd1, 1'b0, 1'b0, 4'b0101, 1'b0, 2'b00);
    vecs[16] = mk(1'b1, 1'b0, 1'b1, 4'b1111, 2'd2, 8'd2, 1'b0, 1'b0, 4'b0010, 1'b0, 2'b00);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 4'b1111, 2'd2, 8'd3, 1'b0, 1'b0, 4'b0001, 1'b0, 2'b00);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 4'b0011, 2'd3, 8'd4, 1'b1, 1'b0, 4'b0000, 1'b1, 2'b01);
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b01);
    vecs[20] = mk(1'b1, 1'b1, 1'b1, 4'b0000, 2'd2, 8'd1, 1'b0, 1'b0, 4'b1000, 1'b0, 2'b01);
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 8'd2, 1'b0, 1'b0, 4'b1100, 1'b0, 2'b01);
    vecs[22] = mk(1'b1, 1'b1, 1'b1, 4'b0000, 2'd2, 8'd3, 1'b0, 1'b0, 4'b1110, 1'b0, 2'b01);
    vecs[23] = mk(1'b1, 1'b1, 1'b0, 4'b0001, 2'd3, 8'd4, 1'b1, 1'b0, 4'b1111, 1'b1, 2'b01);

    // Reset state, checked while reset is still held low.
    rst_instr_n = 1'b0;
    #2;
    check_all("reset", 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00);
    rst_instr_n = 1'b1;
    #2;

    for (int i = 0; i < 24; i++) begin
      edge_ir(vecs[i].sh, vecs[i].tdi, vecs[i].tdo, vecs[i].exp_cap);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].done,
                vecs[i].match, vecs[i].pend, vecs[i].pv, vecs[i].err);
    end

    // Shift directly after reset: only the no-capture flag moves.
    do_reset();
    edge_ir(1'b1, 1'b1, 1'b1, 4'b0001);
    check_all("idle_shift", 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b10);

    // 300 shifts after a capture: counter saturates, pend tracks last 4 tdi.
    do_reset();
    edge_ir(1'b0, 1'b0, 1'b0, 4'b0001);
    model_pend = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      t = ((i % 3) == 0) ? 1'b1 : 1'b0;
      edge_ir(1'b1, t, 1'b0, 4'b0001);
      model_pend = {t, model_pend[3:1]};
    end
    check_all("sat300", 2'd3, 8'd255, 1'b1, 1'b0, model_pend, 1'b1, 2'b01);

    // Reset mid-scan with no clock edge, then a shift without capture.
    do_reset();
    edge_ir(1'b1, 1'b0, 1'b0, 4'b0001);
    edge_ir(1'b0, 1'b0, 1'b0, 4'b0001);
    edge_ir(1'b1, 1'b1, 1'b1, 4'b0001);
    edge_ir(1'b1, 1'b1, 1'b0, 4'b0001);
    edge_ir(1'b1, 1'b1, 1'b0, 4'b0001);
    check_all("pre_abort", 2'd2, 8'd3, 1'b0, 1'b0, 4'b1110, 1'b0, 2'b10);
    rst_instr_n = 1'b0;
    #2;
    check_all("async_rst", 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00);
    #2 rst_instr_n = 1'b1;
    #2;
    edge_ir(1'b1, 1'b1, 1'b0, 4'b0001);
    check_all("post_abort", 2'd0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
